// File: rtl/axis_noc_inject_arbiter_pkg.sv
// ============================================================================
//  Module      : axis_noc_inject_arbiter_pkg
//  Description : Shared NoC types and width helpers for the injection port.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package axis_noc_inject_arbiter_pkg;

    localparam int NOC_FLIT_WIDTH = 32;
    localparam int NOC_DEST_WIDTH = 4;

    typedef struct packed {
        logic [NOC_FLIT_WIDTH-1:0] data;
        logic [NOC_DEST_WIDTH-1:0] dest;
        logic                      is_tail;
    } noc_flit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } noc_state_e;

    // Counter must be able to hold the full depth value itself.
    function automatic int noc_credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int noc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_noc_inject_arbiter_rr_arbiter.sv
// ============================================================================
//  Module      : axis_noc_inject_arbiter_rr_arbiter
//  Description : Combinational round-robin pick starting at a pointer.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module axis_noc_inject_arbiter_rr_arbiter
    import axis_noc_inject_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PTR_WIDTH = noc_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [PTR_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   gnt_oh_o,
    output logic [PTR_WIDTH-1:0] gnt_idx_o,
    output logic                 gnt_vld_o
);

    int w_idx;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        w_idx     = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = (int'(ptr_i) + off) % NUM_REQ;
            if (req_i[w_idx]) begin
                gnt_idx_o = PTR_WIDTH'(w_idx);
                gnt_vld_o = 1'b1;
            end
        end
        if (gnt_vld_o) begin
            gnt_oh_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_noc_inject_arbiter.sv
// ============================================================================
//  Module      : axis_noc_inject_arbiter
//  Description : Packet-locked RR merge of AXIS sources into a credited flit stream.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module axis_noc_inject_arbiter
    import axis_noc_inject_arbiter_pkg::*;
#(
    parameter int NUM_CHANNELS         = 4,
    parameter int TDATA_WIDTH          = 64,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 2,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int FLIT_BUFFER_DEPTH    = 2
) (
    input  logic                                clk_noc,
    input  logic                                rst_n,
    input  logic [NUM_CHANNELS-1:0]             s_axis_tvalid,
    output logic [NUM_CHANNELS-1:0]             s_axis_tready,
    input  logic [NUM_CHANNELS*TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_CHANNELS-1:0]             s_axis_tlast,
    input  logic [NUM_CHANNELS*TID_WIDTH-1:0]   s_axis_tid,
    input  logic [NUM_CHANNELS*TDEST_WIDTH-1:0] s_axis_tdest,
    output logic [FLIT_WIDTH-1:0]               data_out,
    output logic [DEST_WIDTH-1:0]               dest_out,
    output logic                                is_tail_out,
    output logic                                send_out,
    input  logic                                credit_in,
    output logic                                credit_err,
    output logic                                busy
);

    localparam int c_CRED_W = noc_credit_w(FLIT_BUFFER_DEPTH);
    localparam int c_IDX_W  = noc_idx_w(SERIALIZATION_FACTOR);
    localparam int c_PTR_W  = noc_idx_w(NUM_CHANNELS);

    localparam logic [c_CRED_W-1:0] c_CRED_FULL = c_CRED_W'(FLIT_BUFFER_DEPTH);
    localparam logic [c_CRED_W-1:0] c_CRED_ONE  = c_CRED_W'(1);
    localparam logic [c_IDX_W-1:0]  c_LAST_IDX  = c_IDX_W'(SERIALIZATION_FACTOR - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);
    localparam logic [c_PTR_W-1:0]  c_LAST_CH   = c_PTR_W'(NUM_CHANNELS - 1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE   = c_PTR_W'(1);

    noc_state_e              state_q;
    logic [TDATA_WIDTH-1:0]  beat_q;
    logic                    beat_vld_q;
    logic                    beat_last_q;
    logic                    tail_seen_q;
    logic [c_IDX_W-1:0]      flit_idx_q;
    logic [c_IDX_W-1:0]      flit_idx_d;
    logic [c_CRED_W-1:0]     credits_q;
    logic [c_CRED_W-1:0]     credits_d;
    logic                    credit_err_q;
    logic                    credit_err_d;
    logic [c_PTR_W-1:0]      rr_ptr_q;
    logic [c_PTR_W-1:0]      grant_q;
    logic [DEST_WIDTH-1:0]   dest_q;

    logic                    w_send;
    logic                    w_last_flit;
    logic                    w_tail_send;
    logic                    w_capture;
    logic                    w_pick_vld;
    logic [NUM_CHANNELS-1:0] w_pick_oh;
    logic [NUM_CHANNELS-1:0] w_tready;
    logic [c_PTR_W-1:0]      w_pick_idx;
    logic [c_PTR_W-1:0]      w_sel_ch;
    logic [c_PTR_W-1:0]      w_rr_next;
    logic [TDATA_WIDTH-1:0]  w_sel_data;
    logic [DEST_WIDTH-1:0]   w_sel_dest;
    logic                    w_sel_last;

    axis_noc_inject_arbiter_rr_arbiter #(
        .NUM_REQ   (NUM_CHANNELS),
        .PTR_WIDTH (c_PTR_W)
    ) u_rr_arbiter (
        .req_i     (s_axis_tvalid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (w_pick_oh),
        .gnt_idx_o (w_pick_idx),
        .gnt_vld_o (w_pick_vld)
    );

    assign w_send      = beat_vld_q && (credits_q != '0);
    assign w_last_flit = w_send && (flit_idx_q == c_LAST_IDX);
    assign w_tail_send = w_last_flit && beat_last_q;
    assign w_rr_next   = (grant_q == c_LAST_CH) ? '0 : grant_q + c_PTR_ONE;

    assign w_sel_ch   = (state_q == IDLE) ? w_pick_idx : grant_q;
    assign w_sel_data = s_axis_tdata[int'(w_sel_ch)*TDATA_WIDTH +: TDATA_WIDTH];
    assign w_sel_last = s_axis_tlast[w_sel_ch];
    assign w_sel_dest = {s_axis_tid[int'(w_sel_ch)*TID_WIDTH +: TID_WIDTH],
                         s_axis_tdest[int'(w_sel_ch)*TDEST_WIDTH +: TDEST_WIDTH]};

    // A new beat may enter as the held beat's last flit leaves, avoiding a bubble.
    always_comb begin
        w_tready = '0;
        if (state_q == IDLE) begin
            w_tready = w_pick_oh;
        end else if (!tail_seen_q && (!beat_vld_q || w_last_flit)) begin
            w_tready[grant_q] = 1'b1;
        end
    end

    assign w_capture     = |(w_tready & s_axis_tvalid);
    assign s_axis_tready = w_tready & {NUM_CHANNELS{rst_n}};

    always_comb begin
        flit_idx_d = flit_idx_q;
        if (w_send) begin
            flit_idx_d = (flit_idx_q == c_LAST_IDX) ? '0 : flit_idx_q + c_IDX_ONE;
        end
    end

    always_comb begin
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        if (w_send && !credit_in) begin
            credits_d = credits_q - c_CRED_ONE;
        end else if (!w_send && credit_in) begin
            if (credits_q == c_CRED_FULL) begin
                credit_err_d = 1'b1;
            end else begin
                credits_d = credits_q + c_CRED_ONE;
            end
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            beat_vld_q   <= 1'b0;
            beat_last_q  <= 1'b0;
            tail_seen_q  <= 1'b0;
            flit_idx_q   <= '0;
            credits_q    <= c_CRED_FULL;
            credit_err_q <= 1'b0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            dest_q       <= '0;
        end else begin
            flit_idx_q   <= flit_idx_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            if (w_capture) begin
                beat_q      <= w_sel_data;
                beat_vld_q  <= 1'b1;
                beat_last_q <= w_sel_last;
                tail_seen_q <= w_sel_last;
            end else if (w_last_flit) begin
                beat_vld_q  <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (w_capture) begin
                        state_q <= SEND;
                        grant_q <= w_pick_idx;
                        dest_q  <= w_sel_dest;
                    end
                end
                SEND: begin
                    if (w_tail_send) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= w_rr_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out    = beat_q[int'(flit_idx_q)*FLIT_WIDTH +: FLIT_WIDTH];
    assign dest_out    = dest_q;
    assign send_out    = w_send;
    assign is_tail_out = w_tail_send;
    assign credit_err  = credit_err_q;
    assign busy        = (state_q == SEND);

endmodule

`default_nettype wire

// File: tb/tb_axis_noc_inject_arbiter.sv
// ============================================================================
//  Module      : tb_axis_noc_inject_arbiter
//  Description : Randomized and directed bench against a packet-level model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_noc_inject_arbiter;
    import axis_noc_inject_arbiter_pkg::*;

    localparam int N     = 4;
    localparam int TD    = 64;
    localparam int TIDW  = 2;
    localparam int TDW   = 2;
    localparam int SF    = 2;
    localparam int FW    = TD / SF;
    localparam int DW    = TIDW + TDW;
    localparam int DEPTH = 2;

    logic              clk_noc = 1'b0;
    logic              rst_n;
    logic [N-1:0]      s_axis_tvalid;
    logic [N-1:0]      s_axis_tready;
    logic [N*TD-1:0]   s_axis_tdata;
    logic [N-1:0]      s_axis_tlast;
    logic [N*TIDW-1:0] s_axis_tid;
    logic [N*TDW-1:0]  s_axis_tdest;
    logic [FW-1:0]     data_out;
    logic [DW-1:0]     dest_out;
    logic              is_tail_out;
    logic              send_out;
    logic              credit_in;
    logic              credit_err;
    logic              busy;

    always #5 clk_noc = ~clk_noc;

    axis_noc_inject_arbiter dut (
        .clk_noc       (clk_noc),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .data_out      (data_out),
        .dest_out      (dest_out),
        .is_tail_out   (is_tail_out),
        .send_out      (send_out),
        .credit_in     (credit_in),
        .credit_err    (credit_err),
        .busy          (busy)
    );

    typedef struct {
        logic [TD-1:0]   data;
        logic            last;
        logic [TIDW-1:0] tid;
        logic [TDW-1:0]  tdest;
    } beat_t;

    beat_t     src_q [N][$];
    logic [N-1:0] vld;
    bit   [N-1:0] hs_flag;
    noc_flit_t exp_q[$];
    noc_flit_t sent_log[$];
    int        grant_log[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Packet-level reference state
    bit           m_in_pkt;
    bit           m_tail_seen;
    bit           m_err;
    int           m_grant;
    int           m_rr;
    int           m_credits;
    logic [DW-1:0] m_dest;

    logic [N-1:0] e_rdy;
    bit           e_send;
    bit           found;
    int           cc;
    noc_flit_t    f;
    beat_t        b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk_noc) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_send_out", send_out, 0);
            chk("rst_tready", s_axis_tready, 0);
            chk("rst_is_tail", is_tail_out, 0);
            chk("rst_busy", busy, 0);
            chk("rst_credit_err", credit_err, 0);
            chk("rst_data_out", data_out, 0);
            chk("rst_dest_out", dest_out, 0);
            exp_q.delete();
            m_in_pkt    = 0;
            m_tail_seen = 0;
            m_err       = 0;
            m_grant     = 0;
            m_rr        = 0;
            m_credits   = DEPTH;
            m_dest      = '0;
            hs_flag     = '0;
        end else begin
            e_send = (exp_q.size() > 0) && (m_credits > 0);
            e_rdy  = '0;
            if (!m_in_pkt) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    cc = (m_rr + k) % N;
                    if (!found && s_axis_tvalid[cc]) begin
                        e_rdy[cc] = 1'b1;
                        found = 1;
                    end
                end
            end else if (!m_tail_seen && (exp_q.size() == 0 || (e_send && exp_q.size() == 1))) begin
                e_rdy[m_grant] = 1'b1;
            end
            chk("send_out", send_out, e_send);
            chk("tready", s_axis_tready, e_rdy);
            chk("busy", busy, m_in_pkt);
            chk("credit_err", credit_err, m_err);
            if (m_in_pkt) chk("dest_out", dest_out, m_dest);
            if (e_send) begin
                chk("data_out", data_out, exp_q[0].data);
                chk("is_tail_out", is_tail_out, exp_q[0].is_tail);
            end else begin
                chk("is_tail_quiet", is_tail_out, 0);
            end

            // Commit what the coming edge does
            if (e_send) begin
                f = exp_q.pop_front();
                sent_log.push_back(f);
                if (f.is_tail) begin
                    m_in_pkt = 0;
                    m_rr     = (m_grant + 1) % N;
                end
            end
            for (int c = 0; c < N; c++) begin
                if (s_axis_tvalid[c] && s_axis_tready[c] && src_q[c].size() > 0) begin
                    b = src_q[c].pop_front();
                    hs_flag[c] = 1'b1;
                    if (!m_in_pkt) begin
                        m_in_pkt = 1;
                        m_grant  = c;
                        m_dest   = {b.tid, b.tdest};
                        grant_log.push_back(c);
                    end
                    m_tail_seen = b.last;
                    for (int k = 0; k < SF; k++) begin
                        f.data    = b.data[k*FW +: FW];
                        f.dest    = m_dest;
                        f.is_tail = b.last && (k == SF - 1);
                        exp_q.push_back(f);
                    end
                end
            end
            if (e_send && !credit_in) begin
                m_credits--;
            end else if (!e_send && credit_in) begin
                if (m_credits == DEPTH) m_err = 1;
                else m_credits++;
            end
        end
    end

    task automatic step(input bit cr, input int thr);
        @(posedge clk_noc);
        #1;
        for (int c = 0; c < N; c++) begin
            if (hs_flag[c]) begin
                vld[c]     = 1'b0;
                hs_flag[c] = 1'b0;
            end
            if (!vld[c] && src_q[c].size() > 0 && ($urandom_range(99) < thr)) vld[c] = 1'b1;
            if (vld[c]) begin
                s_axis_tdata[c*TD +: TD]     = src_q[c][0].data;
                s_axis_tlast[c]              = src_q[c][0].last;
                s_axis_tid[c*TIDW +: TIDW]   = src_q[c][0].tid;
                s_axis_tdest[c*TDW +: TDW]   = src_q[c][0].tdest;
            end else begin
                s_axis_tdata[c*TD +: TD]     = {$urandom, $urandom};
                s_axis_tlast[c]              = 1'($urandom);
                s_axis_tid[c*TIDW +: TIDW]   = TIDW'($urandom);
                s_axis_tdest[c*TDW +: TDW]   = TDW'($urandom);
            end
        end
        s_axis_tvalid = vld;
        credit_in     = cr;
    endtask

    task automatic push_pkt(input int c, input int nb, input logic [TD-1:0] d0,
                            input logic [TIDW-1:0] tid, input logic [TDW-1:0] tdest);
        beat_t x;
        for (int i = 0; i < nb; i++) begin
            x.data  = (i == 0) ? d0 : {$urandom, $urandom};
            x.last  = (i == nb - 1);
            x.tid   = tid;
            x.tdest = tdest;
            src_q[c].push_back(x);
        end
    endtask

    function automatic bit quiet();
        for (int c = 0; c < N; c++) begin
            if (src_q[c].size() != 0 || vld[c]) return 0;
        end
        return (exp_q.size() == 0) && !m_in_pkt;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        while (!(quiet() && m_credits == DEPTH) && n < 3000) begin
            step(m_credits < DEPTH, 100);
            n++;
        end
        chk({tag, "_drain_done"}, n < 3000, 1);
    endtask

    task automatic do_reset();
        @(posedge clk_noc);
        #1;
        rst_n         = 1'b0;
        vld           = '0;
        s_axis_tvalid = '0;
        credit_in     = 1'b0;
        hs_flag       = '0;
        for (int c = 0; c < N; c++) src_q[c].delete();
        #1;
        chk("rst_now_send_out", send_out, 0);
        chk("rst_now_tready", s_axis_tready, 0);
        chk("rst_now_busy", busy, 0);
        chk("rst_now_is_tail", is_tail_out, 0);
        chk("rst_now_dest_out", dest_out, 0);
        repeat (2) @(posedge clk_noc);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base, gbase, sbase, first;
        bit ok, given;
        rst_n         = 1'b0;
        vld           = '0;
        hs_flag       = '0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tid    = '0;
        s_axis_tdest  = '0;
        credit_in     = 1'b0;
        repeat (3) @(posedge clk_noc);
        #1;
        rst_n = 1'b1;

        // Single-beat packet on ch0
        base = sent_log.size();
        push_pkt(0, 1, 64'h1122334455667788, 2'd1, 2'd2);
        repeat (6) step(0, 100);
        chk("d1_flit_count", sent_log.size() - base, 2);
        if (sent_log.size() >= base + 2) begin
            chk("d1_f0_data", sent_log[base].data, 32'h55667788);
            chk("d1_f1_data", sent_log[base+1].data, 32'h11223344);
            chk("d1_f0_dest", sent_log[base].dest, 4'b0110);
            chk("d1_f0_tail", sent_log[base].is_tail, 0);
            chk("d1_f1_tail", sent_log[base+1].is_tail, 1);
        end
        drain("d1");

        // Credit starvation
        base = sent_log.size();
        push_pkt(0, 2, {$urandom, $urandom}, 2'd0, 2'd3);
        push_pkt(0, 2, {$urandom, $urandom}, 2'd0, 2'd1);
        repeat (12) step(0, 100);
        chk("d2_stall_count", sent_log.size() - base, 2);
        chk("d2_stall_send", send_out, 0);
        chk("d2_stall_tready", s_axis_tready, 0);
        step(1, 100);
        repeat (6) step(0, 100);
        chk("d2_one_credit_count", sent_log.size() - base, 3);
        drain("d2");

        // Round-robin order and packet lock
        do_reset();
        gbase = grant_log.size();
        sbase = sent_log.size();
        push_pkt(0, 1, {$urandom, $urandom}, 2'd0, 2'd0);
        push_pkt(0, 1, {$urandom, $urandom}, 2'd0, 2'd1);
        push_pkt(1, 3, {$urandom, $urandom}, 2'd1, 2'd2);
        push_pkt(1, 1, {$urandom, $urandom}, 2'd1, 2'd3);
        push_pkt(2, 1, {$urandom, $urandom}, 2'd2, 2'd0);
        push_pkt(2, 1, {$urandom, $urandom}, 2'd2, 2'd1);
        drain("d3");
        chk("d3_grant_count", grant_log.size() - gbase, 6);
        if (grant_log.size() >= gbase + 6) begin
            for (int i = 0; i < 6; i++) chk("d3_grant_order", grant_log[gbase+i], i % 3);
        end
        first = -1;
        for (int i = sbase; i < sent_log.size(); i++) begin
            if (first < 0 && sent_log[i].dest[3:2] == 2'd1) first = i;
        end
        ok = (first >= 0);
        for (int i = 0; i < 6; i++) begin
            if (first < 0 || first + i >= sent_log.size() || sent_log[first+i].dest[3:2] != 2'd1) ok = 0;
        end
        chk("d3_ch1_contiguous", ok, 1);

        // Send and credit return together at credits=1
        base  = sent_log.size();
        given = 0;
        push_pkt(2, 2, {$urandom, $urandom}, 2'd2, 2'd2);
        for (int i = 0; i < 10; i++) begin
            if (!given && sent_log.size() - base == 1) begin
                given = 1;
                step(1, 100);
            end else begin
                step(0, 100);
            end
        end
        chk("d4_flit_count", sent_log.size() - base, 3);
        chk("d4_stall_send", send_out, 0);
        drain("d4");

        // Credit overflow is sticky and saturating
        step(1, 100);
        repeat (2) step(0, 100);
        chk("d5_err_set", credit_err, 1);
        repeat (5) step(0, 100);
        chk("d5_err_sticky", credit_err, 1);
        base = sent_log.size();
        push_pkt(1, 2, {$urandom, $urandom}, 2'd1, 2'd0);
        repeat (10) step(0, 100);
        chk("d5_saturated_count", sent_log.size() - base, 2);
        drain("d5");

        // Reset in the middle of a packet
        base = sent_log.size();
        push_pkt(1, 3, {$urandom, $urandom}, 2'd1, 2'd1);
        for (int i = 0; i < 20 && sent_log.size() == base; i++) step(m_credits < DEPTH, 100);
        chk("d6_partial_started", sent_log.size() > base, 1);
        do_reset();
        chk("d6_err_cleared", credit_err, 0);
        gbase = grant_log.size();
        base  = sent_log.size();
        push_pkt(3, 1, 64'hCAFEF00D_A5A55A5A, 2'd3, 2'd1);
        repeat (6) step(0, 100);
        chk("d6_grant_count", grant_log.size() - gbase, 1);
        if (grant_log.size() > gbase) chk("d6_grant_ch3", grant_log[gbase], 3);
        chk("d6_flit_count", sent_log.size() - base, 2);
        if (sent_log.size() >= base + 2) begin
            chk("d6_head_data", sent_log[base].data, 32'hA5A55A5A);
            chk("d6_head_tail", sent_log[base].is_tail, 0);
            chk("d6_tail_tail", sent_log[base+1].is_tail, 1);
        end
        drain("d6");

        // Randomized traffic with random credit return
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(9) == 0) begin
                cc = $urandom_range(N - 1);
                if (src_q[cc].size() < 6)
                    push_pkt(cc, $urandom_range(1, 4), {$urandom, $urandom},
                             TIDW'($urandom), TDW'($urandom));
            end
            step((m_credits < DEPTH) && ($urandom_range(2) != 0), 70);
        end
        drain("rand");
        chk("final_no_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
